// File: rtl/tile_mac_sequencer.sv
// tile_mac_sequencer: drives a 16-bit computation tile through one dot-product
// evaluation (clear, N multiply-accumulates, drain, readback) and latches the
// tile's final value into result, pulsing done for one cycle.
// Optional build macro TILE_SEQ_RELU_EN inserts an ACT state that clamps a
// negative (two's complement) result to zero before done is raised.
module tile_mac_sequencer #(
  parameter int LEN_W  = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic [3:0]        tile_opcode,
  output logic              tile_clear,
  output logic [DATA_W-1:0] tile_in0,
  output logic [DATA_W-1:0] tile_in1,
  input  logic [DATA_W-1:0] tile_cell_out
);

  localparam logic [3:0] OP_READ = 4'd8;
  localparam logic [3:0] OP_MAC  = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_MAC,
    S_DRAIN,
    S_READ,
    S_DONE
`ifdef TILE_SEQ_RELU_EN
    , S_ACT
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   count_q, count_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic               resetSeen_q;
  logic               pairsLeft;

  // Pairs are only requested while the remaining-pair counter is non-zero,
  // which also guarantees the counter can never wrap below zero.
  assign pairsLeft = (count_q != '0);
  assign result    = result_q;

  // State, counter and result registers with synchronous active-low reset;
  // resetSeen_q keeps the tile held in clear for the cycle after a reset edge.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      result_q    <= '0;
      resetSeen_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      result_q    <= result_d;
      resetSeen_q <= 1'b0;
    end
  end

  // Next-state logic and all tile/handshake outputs; the MAC operands are a
  // same-cycle pass-through of the accepted upstream pair.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    result_d    = result_q;
    busy        = 1'b1;
    done        = 1'b0;
    op_ready    = 1'b0;
    tile_opcode = OP_READ;
    tile_clear  = 1'b0;
    tile_in0    = '0;
    tile_in1    = '0;

    case (state_q)
      S_IDLE: begin
        busy       = 1'b0;
        tile_clear = resetSeen_q;
        if (start) begin
          count_d = length;
          state_d = S_CLEAR;
        end
      end

      S_CLEAR: begin
        tile_clear = 1'b1;
        state_d    = pairsLeft ? S_MAC : S_DRAIN;
      end

      S_MAC: begin
        op_ready = pairsLeft;
        if (pairsLeft && op_valid) begin
          tile_opcode = OP_MAC;
          tile_in0    = op_a;
          tile_in1    = op_b;
          count_d     = count_q - LEN_W'(1);
          if (count_q == LEN_W'(1)) begin
            state_d = S_DRAIN;
          end
        end else if (!pairsLeft) begin
          state_d = S_DRAIN;
        end
      end

      S_DRAIN: begin
        tile_opcode = OP_MAC;
        state_d     = S_READ;
      end

      S_READ: begin
        result_d = tile_cell_out;
`ifdef TILE_SEQ_RELU_EN
        state_d  = S_ACT;
`else
        state_d  = S_DONE;
`endif
      end

`ifdef TILE_SEQ_RELU_EN
      S_ACT: begin
        if (result_q[DATA_W-1]) begin
          result_d = '0;
        end
        state_d = S_DONE;
      end
`endif

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_tile_mac_sequencer.sv
// tb_tile_mac_sequencer: directed and randomized dot-product jobs against a
// behavioural tile stub; expected results come from a plain sum-of-products model.
module tb_tile_mac_sequencer;

  logic        clk = 1'b0;
  logic        clear_n;
  logic        start;
  logic [7:0]  length;
  logic        busy, done;
  logic [15:0] result;
  logic        opValid, op_ready;
  logic [15:0] opA, opB;
  logic [3:0]  tile_opcode;
  logic        tile_clear;
  logic [15:0] tile_in0, tile_in1, tile_cell_out;

  int assertCount = 0;
  int failCount   = 0;

  logic [15:0] pa [0:15];
  logic [15:0] pb [0:15];
  int          stallArr [0:16];

`ifdef TILE_SEQ_RELU_EN
  localparam int EXTRA_LAT = 1;
`else
  localparam int EXTRA_LAT = 0;
`endif

  tile_mac_sequencer #(.LEN_W(8), .DATA_W(16)) dut (
    .clk(clk), .clear_n(clear_n), .start(start), .length(length),
    .busy(busy), .done(done), .result(result),
    .op_valid(opValid), .op_ready(op_ready), .op_a(opA), .op_b(opB),
    .tile_opcode(tile_opcode), .tile_clear(tile_clear),
    .tile_in0(tile_in0), .tile_in1(tile_in1), .tile_cell_out(tile_cell_out)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Behavioural tile: clear, or accumulate in0*in1 modulo 2^16 on opcode 15.
  logic [15:0] tileAcc;
  always @(posedge clk) begin
    if (tile_clear) tileAcc <= 16'd0;
    else if (tile_opcode == 4'd15) tileAcc <= tileAcc + 16'(tile_in0 * tile_in1);
  end
  assign tile_cell_out = tileAcc;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Runs one job of len pairs; nOffered pairs are presented upstream (extra ones
  // must never be consumed). injectAt>0 pulses a second start in that cycle.
  task automatic applyStimulus(input string tag, input int len, input int nOffered,
                               input int injectAt);
    int idx = 0;
    int hs = 0;
    int readyCycles = 0;
    int stallTotal = 0;
    int stallLeft;
    int cyc;
    int doneCyc = -1;
    logic [15:0] expVal = 16'd0;

    for (int i = 0; i < len; i++) expVal = expVal + 16'(pa[i] * pb[i]);
`ifdef TILE_SEQ_RELU_EN
    if (expVal[15]) expVal = 16'd0;
`endif

    stallLeft = stallArr[0];
    length = 8'(len);
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    length = 8'($urandom);
    cyc = 1;
    while (doneCyc < 0 && cyc < 300) begin
      opValid = (idx < nOffered) && (stallLeft == 0);
      opA     = opValid ? pa[idx] : 16'($urandom);
      opB     = opValid ? pb[idx] : 16'($urandom);
      start   = (cyc == injectAt);
      length  = 8'd5;
      #1;
      checkOutput({tag, " opLegal"},
                  32'((tile_opcode == 4'd8) || (tile_opcode == 4'd15)), 32'd1);
      if (op_ready) readyCycles++;
      if (op_ready && opValid) begin
        checkOutput({tag, " macOpcode"}, 32'(tile_opcode), 32'd15);
        checkOutput({tag, " in0"}, 32'(tile_in0), 32'(pa[idx]));
        checkOutput({tag, " in1"}, 32'(tile_in1), 32'(pb[idx]));
        hs++;
        idx++;
        stallLeft = stallArr[idx];
      end else if (op_ready && stallLeft > 0) begin
        checkOutput({tag, " stallOpcode"}, 32'(tile_opcode), 32'd8);
        stallLeft--;
        stallTotal++;
      end
      if (done) begin
        doneCyc = cyc;
        checkOutput({tag, " result"}, 32'(result), 32'(expVal));
        checkOutput({tag, " doneCycle"}, 32'(doneCyc), 32'(len + 4 + stallTotal + EXTRA_LAT));
      end
      @(posedge clk); #1;
      cyc++;
    end
    start   = 1'b0;
    opValid = 1'b0;
    if (doneCyc < 0) checkOutput({tag, " timeout"}, 32'd0, 32'd1);
    checkOutput({tag, " handshakes"}, 32'(hs), 32'(len));
    checkOutput({tag, " readyCycles"}, 32'(readyCycles), 32'(len + stallTotal));
    #1;
    checkOutput({tag, " donePulse"}, 32'(done), 32'd0);
    checkOutput({tag, " idleBusy"}, 32'(busy), 32'd0);
    checkOutput({tag, " resultHold"}, 32'(result), 32'(expVal));
  endtask

  task automatic clearStalls();
    for (int i = 0; i <= 16; i++) stallArr[i] = 0;
  endtask

  initial begin
    logic doneSeen;
    int len;
    clear_n = 1'b0; start = 1'b0; length = 8'd0;
    opValid = 1'b0; opA = 16'd0; opB = 16'd0;
    clearStalls();

    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst busy", 32'(busy), 32'd0);
    checkOutput("rst done", 32'(done), 32'd0);
    checkOutput("rst result", 32'(result), 32'd0);
    checkOutput("rst opReady", 32'(op_ready), 32'd0);
    checkOutput("rst opcode", 32'(tile_opcode), 32'd8);
    checkOutput("rst tileClear", 32'(tile_clear), 32'd1);
    clear_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("idle tileClear", 32'(tile_clear), 32'd0);

    // Mid-MAC reset: length 4, two pairs accepted, then clear_n low for 2 cycles
    length = 8'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    opValid = 1'b1; opA = 16'd1; opB = 16'd1;
    @(posedge clk); #1;
    opA = 16'd2; opB = 16'd2;
    @(posedge clk); #1;
    opValid = 1'b0;
    clear_n = 1'b0;
    doneSeen = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      doneSeen |= done;
      checkOutput("midRst busy", 32'(busy), 32'd0);
      checkOutput("midRst tileClear", 32'(tile_clear), 32'd1);
      checkOutput("midRst opcode", 32'(tile_opcode), 32'd8);
      checkOutput("midRst opReady", 32'(op_ready), 32'd0);
    end
    clear_n = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      doneSeen |= done;
    end
    checkOutput("midRst noDone", 32'(doneSeen), 32'd0);

    pa[0] = 16'd3; pb[0] = 16'd4;
    applyStimulus("afterRst", 1, 1, 0);

    // Basic dot product, op_valid held high, one spare pair offered
    pa[0] = 16'd1; pb[0] = 16'd2; pa[1] = 16'd3; pb[1] = 16'd4;
    pa[2] = 16'd5; pb[2] = 16'd6; pa[3] = 16'd77; pb[3] = 16'd99;
    applyStimulus("basic", 3, 4, 0);

    // Same vectors with a 2-cycle stall between pairs
    stallArr[1] = 2;
    applyStimulus("stall", 3, 3, 0);
    clearStalls();

    // Zero length
    applyStimulus("zeroLen", 0, 2, 0);

    // Start with length 5 while a length-2 job is in MAC
    pa[0] = 16'd2; pb[0] = 16'd2; pa[1] = 16'd3; pb[1] = 16'd3;
    pa[2] = 16'd9; pb[2] = 16'd9; pa[3] = 16'd8; pb[3] = 16'd8;
    applyStimulus("busyStart", 2, 4, 2);

    // Wrap-around of the accumulator modulo 2^16
    pa[0] = 16'hFFFF; pb[0] = 16'hFFFF; pa[1] = 16'h8000; pb[1] = 16'd3;
    applyStimulus("wrap", 2, 2, 0);

`ifdef TILE_SEQ_RELU_EN
    pa[0] = 16'hFFFF; pb[0] = 16'd5; pa[1] = 16'd1; pb[1] = 16'd2;
    applyStimulus("reluNeg", 2, 2, 0);
    pa[0] = 16'd2; pb[0] = 16'd3;
    applyStimulus("reluPos", 1, 1, 0);
`endif

    // Randomized jobs with random stalls and occasional busy starts
    for (int j = 0; j < 8; j++) begin
      len = int'($urandom_range(0, 7));
      for (int i = 0; i < 16; i++) begin
        pa[i] = 16'($urandom);
        pb[i] = 16'($urandom);
      end
      for (int i = 0; i <= 16; i++) stallArr[i] = int'($urandom_range(0, 2));
      applyStimulus("random", len, len + int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 4)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/tile_mac_sequencer.md
Name: tile_mac_sequencer

Overview:
- Controller that drives one 16-bit computation tile through a complete dot-product (neuron) evaluation: clear, N multiply-accumulate steps, drain, readback.
- Accepts a start command with a vector length, pulls operand pairs from an upstream valid/ready stream, and issues the tile opcode and operands each cycle.
- Captures the tile's final value into a result register and pulses done.
- Sits between the operand-fetch/weight-memory logic and a computation tile.

Parameters:
LEN_W, 8, width of the vector-length input and the internal remaining-pair counter
DATA_W, 16, operand/result width; must equal the tile datapath width (16)

Ports:
clk  in  1  clock; all state updates on rising edge
clear_n  in  1  synchronous active-low reset
start  in  1  begin evaluation; sampled only in IDLE
length  in  LEN_W  number of operand pairs; sampled with start
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when result is valid
result  out  DATA_W  final value; holds until next done
op_valid  in  1  upstream operand pair valid
op_ready  out  1  sequencer accepts pair this cycle
op_a  in  DATA_W  operand A (input)
op_b  in  DATA_W  operand B (weight)
tile_opcode  out  4  opcode to tile
tile_clear  out  1  active-high clear to tile
tile_in0  out  DATA_W  tile input0
tile_in1  out  DATA_W  tile input1
tile_cell_out  in  DATA_W  tile cellOut

Behaviour:
- Opcodes used: 8 = READ/idle (no accumulate, no register write), 15 = MAC (accumulator enabled). No other opcode is issued.
- States: IDLE, CLEAR, MAC, DRAIN, READ, DONE (plus ACT with the optional feature).
- Reset (clear_n=0 at an edge):
  - state→IDLE; busy=0, done=0, result=0, op_ready=0.
  - tile_opcode=8, tile_clear=1, tile_in0=tile_in1=0.
  - Mid-operation reset abandons the evaluation; no done pulse.
- IDLE:
  - tile_opcode=8, tile_clear=0, operands 0.
  - start=1 latches length into the counter; next state CLEAR.
- CLEAR, one cycle:
  - tile_clear=1, tile_opcode=8.
  - Next state MAC if count>0, else DRAIN (length 0 yields result 0).
- MAC:
  - op_ready=1 while count>0.
  - On op_valid&op_ready: tile_opcode=15, tile_in0=op_a, tile_in1=op_b (combinational pass-through, same cycle); count decrements.
  - If op_valid=0 (stall): tile_opcode=8, operands 0, no accumulation; stalls of any length are allowed.
  - After the handshake that brings count to 0, next state DRAIN.
- DRAIN, one cycle: tile_opcode=15 with tile_in0=tile_in1=0. This adds 0 to the accumulator and settles the tile's output register.
- READ, one cycle: tile_opcode=8; at the end of the cycle, result←tile_cell_out.
- DONE, one cycle: done=1, busy=1; next state IDLE.
- Latency:
  - start sampled at edge k with N pairs and no stalls gives CLEAR at cycle k+1, MAC k+2..k+N+1, DRAIN k+N+2, READ k+N+3, DONE k+N+4.
  - Each stall cycle adds 1.
- Boundary rules:
  - start while busy is ignored.
  - length is only sampled in IDLE.
  - op_ready is 0 outside MAC, so no pair is consumed there.
  - Accumulation wraps modulo 2^16 (tile arithmetic); the sequencer adds no saturation.
  - Counter never underflows.
  - result updates only in READ.

Optional Feature:
- Macro: TILE_SEQ_RELU_EN.
- Defined:
  - ACT state inserted between READ and DONE (+1 cycle latency).
  - In ACT, if result[DATA_W-1]=1 (negative, two's complement), result←0; otherwise unchanged.
  - tile_opcode=8 during ACT.
- Undefined: no ACT state; result is the raw tile value.

Test Plan:
- Reset: hold clear_n=0 for 2 cycles mid-MAC (length=4, 2 pairs sent) → busy=0, done never pulses, tile_clear=1, tile_opcode=8. A fresh start with length=1, pair (3,4) → result=12.
- Basic dot product: length=3, pairs (1,2),(3,4),(5,6), op_valid held high → result=44. done exactly 1 cycle at k+7; exactly 3 cycles with tile_opcode=15 before DRAIN.
- Stalls: same vectors with op_valid low for 2 cycles between pairs → result=44; done at k+9; tile_opcode=8 during stall cycles.
- Zero length: start with length=0 → no op_ready assertion, result=0, done at k+4.
- Start while busy: pulse start with length=5 during MAC of a length=2 job (2,2),(3,3) → result=13; second start ignored; op_ready drops after 2 handshakes.
- RELU (TILE_SEQ_RELU_EN): pairs (0xFFFF,5),(1,2) → tile value 0xFFFD → result=0; pairs (2,3) → result=6; done one cycle later than without the macro.
